staircase_seq_gen: RTL and testbench
====================================

Name: staircase_seq_gen

Overview:
- Parametrised staircase sequence generator. Value k is emitted k times; 0 is emitted once. Up mode produces 0,1,2,2,3,3,3,…,N×N.
- Generalises the fixed-width count-times counter in four ways: runtime up/down direction, optional looping, a valid/ready output stream with backpressure, and explicit start/clear/done control.
- Sits upstream of stimulus and pattern consumers that need a ramp-weighted data stream.

Parameters:
- W, 8, width of value, max and repeat counter; maximum supported N = 2^W-1.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- i_start  in  1  start pulse; accepted only in IDLE.
- i_clear  in  1  synchronous flush to IDLE; higher priority than i_start and any transfer.
- i_max  in  W  N, the final value; latched at start.
- i_dir  in  1  0 = up (0→N), 1 = down (N→0); latched at start.
- i_loop  in  1  1 = restart the sequence after the final beat; latched at start.
- o_data  out  W  current value.
- o_valid  out  1  o_data is valid.
- o_ready  in  1  consumer accepts the beat.
- o_first  out  1  this beat is the first repeat of its value.
- o_last  out  1  this beat is the final beat of a pass.
- o_busy  out  1  state is RUN.
- o_done  out  1  one-cycle pulse after a non-looping pass completes.

Behaviour:
- Reset (rstn=0 at a clk edge): state IDLE. All outputs 0. Internal value, repeat count, max, dir and loop registers all 0.
- States: IDLE and RUN.
- IDLE → RUN:
  - i_start=1 and i_clear=0 at edge t.
  - Latch i_max, i_dir, i_loop at t.
  - At t+1: o_valid=1, o_busy=1, o_first=1. o_data = 0 (up) or N (down).
- i_start in RUN is ignored. Latched fields do not change mid-pass.
- Transfer: o_valid && o_ready at a clk edge.
  - No transfer: o_data, o_first, o_last are held stable.
  - Throughput is one beat per cycle with no bubbles, including across value boundaries and loop restarts.
- Repeat rule: value k has R(k) = max(k,1) beats.
- Repeat counter r: 1 on the first beat of a value, increments each transfer.
  - When r == R(k) and a transfer occurs, step to the next value (k+1 up, k-1 down) and set r=1.
  - o_first = (r==1).
- Final beat:
  - up: k==N && r==N, or N==0.
  - down: k==0.
  - o_last=1 on the final beat only.
- Final-beat transfer with loop=0:
  - Next cycle: IDLE, o_valid=0, o_busy=0, o_last=0, o_done=1 for exactly one cycle.
  - A new i_start is accepted in the cycle after the final transfer, i.e. the cycle o_done is high.
- Final-beat transfer with loop=1:
  - Next cycle: first beat of a new pass (o_first=1).
  - No o_done. Stays in RUN until i_clear.
- i_clear=1 at any edge:
  - Next cycle: IDLE, all outputs 0, no o_done.
  - Any beat in flight is dropped.
- Beat count per pass: 1 + N(N+1)/2.
- Arithmetic:
  - All counters W bits. No wrap is possible because k ≤ N ≤ 2^W-1 and r ≤ N.
  - Step-down past 0 never occurs; the final-beat rule ends the pass first.
- N=0: a single beat per pass with o_data=0, o_first=1, o_last=1, in both directions.
- Down mode with N>0: N repeated N times, then N-1 repeated N-1 times, …, 1 once, 0 once.
- rstn has priority over i_clear. Reset mid-operation behaves exactly as the reset described above.

Test Plan:
- Up, N=4, W=4, o_ready=1, single start:
  - o_data = 0,1,2,2,3,3,3,4,4,4,4 on 11 consecutive cycles starting 1 cycle after start.
  - o_first on beats 1,2,3,5,8.
  - o_last on beat 11; o_done pulses on the following cycle.
- Down, N=3:
  - o_data = 3,3,3,2,2,1,0.
  - o_last on the 0 beat; o_first on beats 1,4,6,7.
- Backpressure, up, N=5, random o_ready (≈50%):
  - o_data/o_first/o_last stable while o_valid && !o_ready.
  - Accepted sequence equals 16 beats of the ideal sequence.
  - o_done follows the last accept by exactly 1 cycle.
- N=0 in both directions:
  - Exactly one beat, o_data=0, o_first=o_last=1, then o_done.
- Loop, up, N=2:
  - Stream 0,1,2,2,0,1,2,2,… with no idle cycle between passes, o_last every 4th beat.
  - i_clear asserted mid-pass → o_valid=0 next cycle, no o_done.
  - i_start issued during RUN before the clear has no effect.
- Corners:
  - W=4, N=15: 121 beats, final value 15 repeated 15 times, no counter overflow.
  - rstn=0 mid-pass → all outputs 0 next cycle.
  - Restart in the o_done cycle → new pass begins with o_valid 1 cycle later.

Source files
------------

// File: rtl/staircase_seq_gen.sv
// Staircase sequence generator: value k is emitted max(k,1) times on a valid/ready stream,
// ascending 0..N or descending N..0, with optional looping and start/clear/done control.
module staircase_seq_gen #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_start,
  input  logic         i_clear,
  input  logic [W-1:0] i_max,
  input  logic         i_dir,
  input  logic         i_loop,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         o_ready,
  output logic         o_first,
  output logic         o_last,
  output logic         o_busy,
  output logic         o_done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [W-1:0] ZERO = W'(0);
  localparam logic [W-1:0] ONE  = W'(1);

  state_t       state_r;
  logic [W-1:0] k_r;
  logic [W-1:0] r_r;
  logic [W-1:0] max_r;
  logic         dir_r;
  logic         loop_r;
  logic         valid_r;
  logic         first_r;
  logic         last_r;
  logic         done_r;

  logic [W-1:0] rep_s;
  logic         step_s;
  logic [W-1:0] k_nxt_s;
  logic [W-1:0] r_nxt_s;
  logic         last_nxt_s;
  logic [W-1:0] start_k_s;
  logic [W-1:0] restart_k_s;
  logic         xfer_s;

  // Next-beat position and final-beat detection for the beat after the current one.
  always_comb begin
    rep_s       = ZERO;
    step_s      = 1'b0;
    k_nxt_s     = k_r;
    r_nxt_s     = r_r;
    last_nxt_s  = 1'b0;
    start_k_s   = ZERO;
    restart_k_s = ZERO;
    xfer_s      = valid_r & o_ready;

    if (k_r == ZERO) begin
      rep_s = ONE;
    end else begin
      rep_s = k_r;
    end
    step_s = (r_r == rep_s);

    if (step_s) begin
      r_nxt_s = ONE;
      if (dir_r) begin
        k_nxt_s = k_r - ONE;
      end else begin
        k_nxt_s = k_r + ONE;
      end
    end else begin
      r_nxt_s = r_r + ONE;
      k_nxt_s = k_r;
    end

    if (dir_r) begin
      last_nxt_s = (k_nxt_s == ZERO);
    end else begin
      last_nxt_s = ((k_nxt_s == max_r) && (r_nxt_s == max_r)) || (max_r == ZERO);
    end

    if (i_dir) begin
      start_k_s = i_max;
    end else begin
      start_k_s = ZERO;
    end

    if (dir_r) begin
      restart_k_s = max_r;
    end else begin
      restart_k_s = ZERO;
    end
  end

  // Sequencer state, counters and registered stream outputs; reset beats clear beats start.
  always_ff @(posedge clk) begin
    if (!rstn || i_clear) begin
      state_r <= IDLE;
      k_r     <= ZERO;
      r_r     <= ZERO;
      max_r   <= ZERO;
      dir_r   <= 1'b0;
      loop_r  <= 1'b0;
      valid_r <= 1'b0;
      first_r <= 1'b0;
      last_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (i_start) begin
            state_r <= RUN;
            max_r   <= i_max;
            dir_r   <= i_dir;
            loop_r  <= i_loop;
            k_r     <= start_k_s;
            r_r     <= ONE;
            valid_r <= 1'b1;
            first_r <= 1'b1;
            last_r  <= (i_max == ZERO);
          end else begin
            state_r <= IDLE;
            valid_r <= 1'b0;
            first_r <= 1'b0;
            last_r  <= 1'b0;
          end
        end
        RUN: begin
          done_r <= 1'b0;
          if (xfer_s && last_r && loop_r) begin
            // Loop restart lands on the next cycle so the stream has no bubble.
            k_r     <= restart_k_s;
            r_r     <= ONE;
            first_r <= 1'b1;
            last_r  <= (max_r == ZERO);
          end else if (xfer_s && last_r) begin
            state_r <= IDLE;
            k_r     <= ZERO;
            r_r     <= ZERO;
            valid_r <= 1'b0;
            first_r <= 1'b0;
            last_r  <= 1'b0;
            done_r  <= 1'b1;
          end else if (xfer_s) begin
            k_r     <= k_nxt_s;
            r_r     <= r_nxt_s;
            first_r <= (r_nxt_s == ONE);
            last_r  <= last_nxt_s;
          end else begin
            k_r <= k_r;
          end
        end
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
          first_r <= 1'b0;
          last_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign o_data  = k_r;
  assign o_valid = valid_r;
  assign o_first = first_r;
  assign o_last  = last_r;
  assign o_busy  = (state_r == RUN);
  assign o_done  = done_r;

endmodule

// File: tb/tb_staircase_seq_gen.sv
// Scoreboard bench for staircase_seq_gen (W=4): expected beats are queued at start and
// compared as the DUT transfers them; control outputs are checked around each pass.
module tb_staircase_seq_gen;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rstn;
  logic         i_start;
  logic         i_clear;
  logic [W-1:0] i_max;
  logic         i_dir;
  logic         i_loop;
  logic [W-1:0] o_data;
  logic         o_valid;
  logic         o_ready;
  logic         o_first;
  logic         o_last;
  logic         o_busy;
  logic         o_done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] d;
    logic         f;
    logic         l;
  } beat_t;

  beat_t exp_q[$];

  staircase_seq_gen #(.W(W)) dut (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_clear(i_clear),
    .i_max(i_max), .i_dir(i_dir), .i_loop(i_loop),
    .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready),
    .o_first(o_first), .o_last(o_last), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Ideal pass: each value k repeated max(k,1) times; last flag on beat 1+N(N+1)/2.
  task automatic push_pass(input int n, input bit dir);
    int total = 1 + n * (n + 1) / 2;
    int idx = 0;
    for (int s = 0; s <= n; s++) begin
      int k = dir ? (n - s) : s;
      int rep = (k == 0) ? 1 : k;
      for (int r = 1; r <= rep; r++) begin
        beat_t b;
        idx++;
        b.d = W'(k);
        b.f = (r == 1);
        b.l = (idx == total);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic start(input int n, input bit dir, input bit lp);
    i_max   = W'(n);
    i_dir   = dir;
    i_loop  = lp;
    i_start = 1'b1;
  endtask

  // Consume nbeats transfers, checking stream content, no bubbles, and hold under stall.
  task automatic drain(input int nbeats, input bit rnd);
    int got = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [W-1:0] pd;
    logic pf, pl;
    while (got < nbeats && cyc < 2000) begin
      @(negedge clk);
      i_start = 1'b0;
      cyc++;
      chk("valid", {31'd0, o_valid}, 32'd1);
      chk("busy", {31'd0, o_busy}, 32'd1);
      if (stalled) begin
        chk("hold_data", {28'd0, o_data}, {28'd0, pd});
        chk("hold_first", {31'd0, o_first}, {31'd0, pf});
        chk("hold_last", {31'd0, o_last}, {31'd0, pl});
      end
      o_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_valid && o_ready) begin
        beat_t e;
        if (exp_q.size() == 0) begin
          chk("queue_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("data", {28'd0, o_data}, {28'd0, e.d});
          chk("first", {31'd0, o_first}, {31'd0, e.f});
          chk("last", {31'd0, o_last}, {31'd0, e.l});
        end
        got++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        pd = o_data;
        pf = o_first;
        pl = o_last;
      end
    end
    chk("beats_in_budget", got, nbeats);
  endtask

  task automatic check_done_pulse(input string tag);
    @(negedge clk);
    chk({tag, "_done"}, {31'd0, o_done}, 32'd1);
    chk({tag, "_valid0"}, {31'd0, o_valid}, 32'd0);
    chk({tag, "_busy0"}, {31'd0, o_busy}, 32'd0);
    chk({tag, "_last0"}, {31'd0, o_last}, 32'd0);
    @(negedge clk);
    chk({tag, "_done_once"}, {31'd0, o_done}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk(tag, {26'd0, o_data, o_valid, o_first, o_last, o_busy, o_done}, 32'd0);
  endtask

  initial begin
    rstn = 1'b0; i_start = 1'b0; i_clear = 1'b0; i_max = '0;
    i_dir = 1'b0; i_loop = 1'b0; o_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_outputs");
    rstn = 1'b1;
    @(negedge clk);
    check_all_zero("idle_outputs");

    // Up, N=4
    push_pass(4, 1'b0); start(4, 1'b0, 1'b0);
    drain(11, 1'b0); check_done_pulse("up4");

    // Down, N=3
    push_pass(3, 1'b1); start(3, 1'b1, 1'b0);
    drain(7, 1'b0); check_done_pulse("down3");

    // Backpressure, up, N=5
    push_pass(5, 1'b0); start(5, 1'b0, 1'b0);
    drain(16, 1'b1); check_done_pulse("bp5");

    // N=0 both directions
    push_pass(0, 1'b0); start(0, 1'b0, 1'b0);
    drain(1, 1'b0); check_done_pulse("zero_up");
    push_pass(0, 1'b1); start(0, 1'b1, 1'b0);
    drain(1, 1'b0); check_done_pulse("zero_down");

    // Loop, up, N=2: ignored start in RUN, then clear mid-stream
    push_pass(2, 1'b0); push_pass(2, 1'b0); push_pass(2, 1'b0);
    start(2, 1'b0, 1'b1);
    drain(6, 1'b0);
    i_max = W'(7); i_dir = 1'b1; i_start = 1'b1;
    drain(3, 1'b0);
    @(negedge clk);
    chk("loop_pre_clear_valid", {31'd0, o_valid}, 32'd1);
    i_clear = 1'b1; o_ready = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
    check_all_zero("clear_outputs");
    @(negedge clk);
    chk("clear_no_done", {31'd0, o_done}, 32'd0);
    exp_q.delete();

    // Corner: N=15 at W=4
    push_pass(15, 1'b0); start(15, 1'b0, 1'b0);
    drain(121, 1'b0); check_done_pulse("up15");

    // Reset mid-pass
    push_pass(3, 1'b0); start(3, 1'b0, 1'b0);
    drain(4, 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    check_all_zero("midpass_reset");
    rstn = 1'b1;
    exp_q.delete();
    @(negedge clk);

    // Restart in the o_done cycle
    push_pass(2, 1'b1); start(2, 1'b1, 1'b0);
    drain(4, 1'b0);
    @(negedge clk);
    chk("restart_done", {31'd0, o_done}, 32'd1);
    push_pass(1, 1'b0); start(1, 1'b0, 1'b0);
    drain(2, 1'b0); check_done_pulse("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
